// File: rtl/conv_coeff_sequencer.sv
// rtl/conv_coeff_sequencer.sv - coefficient register file controller: burst kernel load and per-tap streaming to the MAC
module conv_coeff_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5,
  parameter int ADDR  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [WIDTH*DEPTH-1:0]   cfg_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     loaded,
  output logic                     rf_wr_en,
  output logic                     rf_rd_en,
  output logic [WIDTH*DEPTH-1:0]   rf_wr_data,
  output logic [ADDR*DEPTH-1:0]    rf_addr,
  input  logic [WIDTH-1:0]         rf_rd_data,
  input  logic                     rf_rd_valid,
  output logic                     coef_valid,
  input  logic                     coef_ready,
  output logic [WIDTH-1:0]         coef_data,
  output logic [ADDR-1:0]          coef_tap,
  output logic                     coef_last,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_WAIT, S_OUT, S_DONE
  } state_t;

  localparam logic [ADDR-1:0] LAST_TAP = ADDR'(DEPTH - 1);

  state_t                  state;
  logic [ADDR-1:0]         tap;
  logic [ADDR*DEPTH-1:0]   seq_addr;

  // Burst write addresses every slot with its own index.
  for (genvar i = 0; i < DEPTH; i++) begin : g_seq
    assign seq_addr[i*ADDR +: ADDR] = ADDR'(i);
  end

  assign cfg_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tap        <= '0;
      loaded     <= 1'b0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      rf_wr_data <= '0;
      rf_addr    <= '0;
      coef_valid <= 1'b0;
      coef_data  <= '0;
      coef_tap   <= '0;
      coef_last  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      rf_addr  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            rf_wr_data <= cfg_data;
            rf_wr_en   <= 1'b1;
            rf_addr    <= seq_addr;
            state      <= S_WRITE;
          end else if (start && loaded) begin
            tap      <= '0;
            rf_rd_en <= 1'b1;
            state    <= S_READ;
          end
        end
        S_WRITE: begin
          loaded <= 1'b1;
          state  <= S_IDLE;
        end
        S_READ: state <= S_WAIT;
        S_WAIT: begin
          if (rf_rd_valid) begin
            coef_data  <= rf_rd_data;
            coef_tap   <= tap;
            coef_last  <= (tap == LAST_TAP);
            coef_valid <= 1'b1;
            state      <= S_OUT;
          end else begin
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_OUT: begin
          // Captured tap is held here; back-pressure never triggers a re-read.
          if (coef_ready) begin
            coef_valid <= 1'b0;
            coef_last  <= 1'b0;
            if (tap == LAST_TAP) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              tap      <= tap + ADDR'(1);
              rf_rd_en <= 1'b1;
              rf_addr  <= {{(ADDR*(DEPTH-1)){1'b0}}, tap + ADDR'(1)};
              state    <= S_READ;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_coeff_sequencer.sv
// tb/tb_conv_coeff_sequencer.sv - directed self-checking bench for conv_coeff_sequencer
module tb_conv_coeff_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [39:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        loaded;
  logic        rf_wr_en;
  logic        rf_rd_en;
  logic [39:0] rf_wr_data;
  logic [14:0] rf_addr;
  logic [7:0]  rf_rd_data = '0;
  logic        rf_rd_valid = 1'b0;
  logic        coef_valid;
  logic        coef_ready = 1'b1;
  logic [7:0]  coef_data;
  logic [2:0]  coef_tap;
  logic        coef_last;
  logic        done;
  logic        err;

  logic        rd_fail = 1'b0;
  logic [7:0]  mem [8];
  int          tests = 0;
  int          failed = 0;

  conv_coeff_sequencer #(.WIDTH(8), .DEPTH(5), .ADDR(3)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .start(start), .busy(busy), .loaded(loaded),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_wr_data(rf_wr_data),
    .rf_addr(rf_addr), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .coef_tap(coef_tap), .coef_last(coef_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Register file model: one-cycle read latency, rd_fail suppresses the valid.
  always @(posedge clk) begin
    if (rf_wr_en)
      for (int i = 0; i < 5; i++) mem[rf_addr[i*3 +: 3]] <= rf_wr_data[i*8 +: 8];
    rf_rd_valid <= rf_rd_en && !rd_fail;
    rf_rd_data  <= mem[rf_addr[2:0]];
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stream(input logic [7:0] base, input int stall_tap, input int stall_n, input int exp_done);
    int h, rd_cnt, done_k, done_cnt, left;
    h = 0; rd_cnt = 0; done_k = -1; done_cnt = 0; left = stall_n;
    start = 1'b1; coef_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (rf_rd_en) rd_cnt++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (coef_valid) begin
        if (int'(coef_tap) == stall_tap && left > 0) begin
          coef_ready = 1'b0;
          left--;
          check("hold_data", 40'(coef_data), 40'(base + 8'(stall_tap)));
        end else begin
          coef_ready = 1'b1;
          check("tap_cycle", 40'(k), 40'(3 * (h + 1) + ((h >= stall_tap) ? stall_n : 0)));
          check("tap_data", 40'(coef_data), 40'(base + 8'(h)));
          check("tap_index", 40'(coef_tap), 40'(h));
          check("tap_last", 40'(coef_last), 40'(h == 4));
          h++;
        end
      end else begin
        coef_ready = 1'b1;
      end
      tick();
    end
    check("taps_seen", 40'(h), 40'd5);
    check("done_cycle", 40'(done_k), 40'(exp_done));
    check("done_pulses", 40'(done_cnt), 40'd1);
    check("rd_pulses", 40'(rd_cnt), 40'd5);
    check("idle_after", 40'(busy), 40'd0);
  endtask

  initial begin
    int cnt, cnt2, cnt3, err_k, found;

    // Reset state
    tick(); tick();
    check("rst_cfg_ready", 40'(cfg_ready), 40'd1);
    check("rst_busy", 40'(busy), 40'd0);
    check("rst_loaded", 40'(loaded), 40'd0);
    check("rst_wr_en", 40'(rf_wr_en), 40'd0);
    check("rst_rd_en", 40'(rf_rd_en), 40'd0);
    check("rst_addr", 40'(rf_addr), 40'd0);
    check("rst_wr_data", rf_wr_data, 40'd0);
    check("rst_coef_valid", 40'(coef_valid), 40'd0);
    check("rst_done", 40'(done), 40'd0);
    check("rst_err", 40'(err), 40'd0);
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("start_unloaded_busy", 40'(busy), 40'd0);

    // Kernel load
    cfg_data  = {8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("load_wr_en", 40'(rf_wr_en), 40'd1);
    check("load_addr", 40'(rf_addr), 40'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
    check("load_wr_data", rf_wr_data, 40'h0E0D0C0B0A);
    tick();
    check("load_wr_en_off", 40'(rf_wr_en), 40'd0);
    check("load_loaded", 40'(loaded), 40'd1);
    check("load_cfg_ready", 40'(cfg_ready), 40'd1);

    // Full-rate stream, then a 4-cycle stall on tap 2
    stream(8'h0A, 99, 0, 16);
    stream(8'h0A, 2, 4, 20);

    // Simultaneous load and start: load wins, no stream
    cfg_data  = {8'h15, 8'h14, 8'h13, 8'h12, 8'h11};
    cfg_valid = 1'b1; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    check("both_wr_en", 40'(rf_wr_en), 40'd1);
    check("both_wr_data", rf_wr_data, 40'h1514131211);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (rf_rd_en || coef_valid) cnt++;
      tick();
    end
    check("both_no_stream", 40'(cnt), 40'd0);
    stream(8'h11, 99, 0, 16);

    // Reset while tap 3 is presented
    start = 1'b1; coef_ready = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (coef_valid && coef_tap == 3'd3) found = 1;
      else tick();
    end
    check("reach_tap3", 40'(found), 40'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 40'(busy), 40'd0);
    check("abort_coef_valid", 40'(coef_valid), 40'd0);
    check("abort_done", 40'(done), 40'd0);
    check("abort_loaded", 40'(loaded), 40'd0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (done || rf_rd_en) cnt++;
      tick();
    end
    check("abort_quiet", 40'(cnt), 40'd0);

    // Missing read valid -> err pulse
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    rd_fail = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0; cnt2 = 0; cnt3 = 0; err_k = -1;
    for (int k = 1; k <= 8; k++) begin
      if (err) begin
        cnt++;
        if (err_k < 0) err_k = k;
      end
      if (coef_valid) cnt2++;
      if (done) cnt3++;
      tick();
    end
    rd_fail = 1'b0;
    check("err_cycle", 40'(err_k), 40'd3);
    check("err_pulses", 40'(cnt), 40'd1);
    check("err_no_valid", 40'(cnt2), 40'd0);
    check("err_no_done", 40'(cnt3), 40'd0);
    check("err_idle", 40'(busy), 40'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
